// File: rtl/tmds_channel_decoder_pkg.sv
// Shared TMDS receive definitions: control tokens, FSM states, defaults.
// Token values mirror the transmit-side encoder bit for bit.
package tmds_channel_decoder_pkg;

  localparam int CTRL_RUN_DEF  = 8;
  localparam int BLANK_TMO_DEF = 4096;
  localparam int TMO_W_DEF     = 13;

  localparam logic [3:0] SLIP_LAST = 4'd9;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b symbol decode: control token match and 8b data recovery.
// Data path undoes the DC-balance inversion, then the XOR/XNOR chain.
module tmds_symbol_decode
  import tmds_channel_decoder_pkg::*;
(
  input  logic [9:0] w,
  output logic [7:0] q,
  output logic       is_ctrl,
  output logic [1:0] c
);

  logic [7:0] d;

  assign d = w[9] ? ~w[7:0] : w[7:0];

  always_comb begin
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = w[8] ? (d[i] ^ d[i-1])
                  : ~(d[i] ^ d[i-1]);
    end
  end

  always_comb begin
    is_ctrl = 1'b1;
    c       = 2'b00;
    unique case (1'b1)
      (w == CTRL_TOKEN_00): c = 2'b00;
      (w == CTRL_TOKEN_01): c = 2'b01;
      (w == CTRL_TOKEN_10): c = 2'b10;
      (w == CTRL_TOKEN_11): c = 2'b11;
      default:              is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment on control-token runs,
// then registered pixel / control / DE decode.
module tmds_channel_decoder
  import tmds_channel_decoder_pkg::*;
#(
  parameter int CTRL_RUN  = CTRL_RUN_DEF,
  parameter int BLANK_TMO = BLANK_TMO_DEF,
  parameter int TMO_W     = TMO_W_DEF
) (
  input  logic       pixelclk,
  input  logic       Rst_p,
  input  logic [9:0] raw_din,
  output logic       aligned,
  output logic [3:0] slip_pos,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de
);

  localparam int RUN_W =
    (CTRL_RUN > 2) ? $clog2(CTRL_RUN) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST =
    RUN_W'(CTRL_RUN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(BLANK_TMO - 1);

  logic [19:0]      hist;
  logic [9:0]       w;
  logic [7:0]       q;
  logic             is_ctrl;
  logic [1:0]       c;
  state_t           state;
  logic [RUN_W-1:0] run;
  logic [TMO_W-1:0] tmo;

  // Older word sits in the low half, so offset p picks wire bits p..p+9.
  assign w = 10'(hist >> slip_pos);

  tmds_symbol_decode u_sym (
    .w       (w),
    .q       (q),
    .is_ctrl (is_ctrl),
    .c       (c)
  );

  always_ff @(posedge pixelclk) begin
    if (Rst_p) begin
      hist     <= '0;
      state    <= SEARCH;
      run      <= '0;
      tmo      <= '0;
      slip_pos <= '0;
      aligned  <= 1'b0;
      dout     <= '0;
      de       <= 1'b0;
      c0       <= 1'b0;
      c1       <= 1'b0;
    end else begin
      hist <= {raw_din, hist[19:10]};
      if (state == SEARCH) begin
        if (!is_ctrl) begin
          run      <= '0;
          slip_pos <= (slip_pos == SLIP_LAST)
                      ? 4'd0 : slip_pos + 4'd1;
        end else if (run == RUN_LAST) begin
          state    <= LOCKED;
          aligned  <= 1'b1;
          tmo      <= '0;
          de       <= 1'b0;
          {c1, c0} <= c;
        end else begin
          run <= run + 1'b1;
        end
      end else if (is_ctrl) begin
        tmo      <= '0;
        de       <= 1'b0;
        {c1, c0} <= c;
      end else if (tmo == TMO_LAST) begin
        state   <= SEARCH;
        aligned <= 1'b0;
        run     <= '0;
        de      <= 1'b0;
        dout    <= '0;
      end else begin
        tmo  <= tmo + 1'b1;
        de   <= 1'b1;
        dout <= q;
      end
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: TMDS encoder + bit-stream model,
// directed lock / decode / timeout cases and randomized traffic.
module tb_tmds_channel_decoder;

  localparam int RUN = 8;
  localparam int TMO = 4096;

  localparam logic [9:0] T00 = 10'h354;
  localparam logic [9:0] T01 = 10'h0AB;
  localparam logic [9:0] T10 = 10'h154;
  localparam logic [9:0] T11 = 10'h2AB;

  logic       pixelclk;
  logic       Rst_p;
  logic [9:0] raw_din;
  logic       aligned;
  logic [3:0] slip_pos;
  logic [7:0] dout;
  logic       c0;
  logic       c1;
  logic       de;

  tmds_channel_decoder dut (
    .pixelclk (pixelclk),
    .Rst_p    (Rst_p),
    .raw_din  (raw_din),
    .aligned  (aligned),
    .slip_pos (slip_pos),
    .dout     (dout),
    .c0       (c0),
    .c1       (c1),
    .de       (de)
  );

  initial pixelclk = 1'b0;
  always #5 pixelclk = ~pixelclk;

  int checks = 0;
  int failures = 0;

  // Reference: last two raw words as a bit stream, plus receiver state.
  logic [9:0] m_prev[$];
  bit         m_lock;
  int         m_pos;
  int         m_run;
  int         m_quiet;
  logic [1:0] m_c;
  bit         m_de;
  logic [7:0] m_dout;

  bit         inv_ok[0:1023];
  logic [7:0] inv_byte[0:1023];
  int         disp;
  bit         bitq[$];

  typedef struct {
    bit         is_tok;
    logic [9:0] tok;
    logic [7:0] pix;
    bit         exp_de;
    logic [1:0] exp_c;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [8:0] tmds_qm(input logic [7:0] b);
    int n1;
    bit xn;
    logic [8:0] qm;
    n1 = $countones(b);
    xn = (n1 > 4) || (n1 == 4 && !b[0]);
    qm[0] = b[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xn ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    qm[8] = !xn;
    return qm;
  endfunction

  function automatic logic [9:0] tmds_enc(input logic [7:0] b);
    logic [8:0] qm;
    logic [9:0] r;
    int ones;
    int zeros;
    qm = tmds_qm(b);
    ones = $countones(qm[7:0]);
    zeros = 8 - ones;
    if (disp == 0 || ones == zeros) begin
      r = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp += qm[8] ? (ones - zeros) : (zeros - ones);
    end else if ((disp > 0 && ones > zeros) ||
                 (disp < 0 && zeros > ones)) begin
      r = {1'b1, qm[8], ~qm[7:0]};
      disp += (qm[8] ? 2 : 0) + zeros - ones;
    end else begin
      r = {1'b0, qm[8], qm[7:0]};
      disp += (qm[8] ? 0 : -2) + ones - zeros;
    end
    return r;
  endfunction

  function automatic int tok_c(input logic [9:0] w);
    if (w == T00) return 0;
    if (w == T01) return 1;
    if (w == T10) return 2;
    if (w == T11) return 3;
    return -1;
  endfunction

  task automatic model_edge(input logic [9:0] d, input bit rst);
    logic [19:0] s;
    logic [9:0]  win;
    int          tc;
    if (rst) begin
      m_prev.delete();
      m_lock = 0; m_pos = 0; m_run = 0; m_quiet = 0;
      m_c = 2'b00; m_de = 0; m_dout = 8'h00;
      return;
    end
    s = '0;
    if (m_prev.size() >= 1) s[19:10] = m_prev[m_prev.size()-1];
    if (m_prev.size() >= 2) s[9:0] = m_prev[m_prev.size()-2];
    win = 10'(s >> m_pos);
    tc = tok_c(win);
    if (!m_lock) begin
      if (tc >= 0) begin
        if (m_run + 1 >= RUN) begin
          m_lock = 1; m_quiet = 0; m_de = 0; m_c = 2'(tc);
        end else m_run++;
      end else begin
        m_run = 0;
        m_pos = (m_pos + 1) % 10;
      end
    end else if (tc >= 0) begin
      m_quiet = 0; m_de = 0; m_c = 2'(tc);
    end else if (m_quiet + 1 >= TMO) begin
      m_lock = 0; m_run = 0; m_de = 0; m_dout = 8'h00;
    end else begin
      m_quiet++;
      m_de = 1;
      if (!inv_ok[win]) begin
        failures++;
        $display("FAIL codeword t=%0t word=%h not a data symbol", $time, win);
      end
      m_dout = inv_byte[win];
    end
    m_prev.push_back(d);
    if (m_prev.size() > 2) void'(m_prev.pop_front());
  endtask

  task automatic step(input logic [9:0] d, input bit rst);
    raw_din = d;
    Rst_p = rst;
    @(posedge pixelclk);
    model_edge(d, rst);
    @(negedge pixelclk);
    checks++;
    if ({aligned, slip_pos, de, c1, c0, dout} !==
        {m_lock, 4'(m_pos), m_de, m_c, m_dout}) begin
      failures++;
      $display("FAIL model t=%0t got a=%b s=%0d de=%b c=%b%b d=%h exp a=%b s=%0d de=%b c=%b d=%h",
               $time, aligned, slip_pos, de, c1, c0, dout,
               m_lock, m_pos, m_de, m_c, m_dout);
    end
  endtask

  task automatic expect_eq(input string nm,
                           input logic [31:0] act,
                           input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic tx_word(input logic [9:0] w);
    logic [9:0] o;
    for (int i = 0; i < 10; i++) bitq.push_back(w[i]);
    for (int i = 0; i < 10; i++) o[i] = bitq.pop_front();
    step(o, 1'b0);
  endtask

  task automatic tx_reset(input int shift, input int cycles);
    for (int i = 0; i < cycles; i++) step(10'($urandom), 1'b1);
    bitq.delete();
    disp = 0;
    for (int i = 0; i < shift; i++) bitq.push_back(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t bench did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int rise;
    int sh;
    int len;
    logic [9:0] tk;

    tbl[0] = '{0, 10'h000, 8'hA5, 1, 2'b00};
    tbl[1] = '{0, 10'h000, 8'h00, 1, 2'b00};
    tbl[2] = '{1, T11,     8'h00, 0, 2'b11};
    tbl[3] = '{0, 10'h000, 8'h3C, 1, 2'b11};
    tbl[4] = '{0, 10'h000, 8'hFF, 1, 2'b11};
    tbl[5] = '{1, T10,     8'h00, 0, 2'b10};
    tbl[6] = '{0, 10'h000, 8'h01, 1, 2'b10};
    tbl[7] = '{1, T01,     8'h00, 0, 2'b01};
    tbl[8] = '{0, 10'h000, 8'h80, 1, 2'b01};
    tbl[9] = '{1, T00,     8'h00, 0, 2'b00};

    for (int i = 0; i < 1024; i++) begin
      inv_ok[i] = 0;
      inv_byte[i] = 8'h00;
    end
    for (int b = 0; b < 256; b++) begin
      logic [8:0] qm;
      qm = tmds_qm(8'(b));
      inv_ok[{1'b0, qm[8], qm[7:0]}] = 1;
      inv_byte[{1'b0, qm[8], qm[7:0]}] = 8'(b);
      inv_ok[{1'b1, qm[8], ~qm[7:0]}] = 1;
      inv_byte[{1'b1, qm[8], ~qm[7:0]}] = 8'(b);
    end

    Rst_p = 1'b1;
    raw_din = '0;
    disp = 0;

    tx_reset(0, 3);
    expect_eq("rst_aligned", 32'(aligned), 0);
    expect_eq("rst_slip", 32'(slip_pos), 0);
    expect_eq("rst_dout", 32'(dout), 0);
    expect_eq("rst_de", 32'(de), 0);
    expect_eq("rst_c", 32'({c1, c0}), 0);

    rise = -1;
    for (int i = 0; i < 25; i++) begin
      tx_word(T00);
      if (aligned && rise < 0) rise = i;
    end
    expect_eq("lock0_step", 32'(rise), 17);
    expect_eq("lock0_aligned", 32'(aligned), 1);
    expect_eq("lock0_slip", 32'(slip_pos), 0);
    expect_eq("lock0_c", 32'({c1, c0}), 0);

    for (int i = 0; i < 12; i++) begin
      if (i < 10)
        tx_word(tbl[i].is_tok ? tbl[i].tok : tmds_enc(tbl[i].pix));
      else
        tx_word(T00);
      if (i >= 2) begin
        checks++;
        if ({aligned, de, c1, c0, de ? dout : 8'h00} !==
            {1'b1, tbl[i-2].exp_de, tbl[i-2].exp_c,
             tbl[i-2].exp_de ? tbl[i-2].pix : 8'h00}) begin
          failures++;
          $display("FAIL table[%0d] got a=%b de=%b c=%b%b d=%h exp de=%b c=%b d=%h",
                   i - 2, aligned, de, c1, c0, dout,
                   tbl[i-2].exp_de, tbl[i-2].exp_c, tbl[i-2].pix);
        end
      end
    end

    step(10'($urandom), 1'b1);
    expect_eq("midlock_rst_aligned", 32'(aligned), 0);
    expect_eq("midlock_rst_de", 32'(de), 0);

    tx_reset(7, 1);
    rise = -1;
    for (int i = 0; i < 30; i++) begin
      tx_word(T01);
      if (i < 10)
        expect_eq($sformatf("walk7_%0d", i), 32'(slip_pos),
                  (i + 1 < 7) ? i + 1 : 7);
      if (aligned && rise < 0) rise = i;
    end
    expect_eq("lock7_step", 32'(rise), 14);
    expect_eq("lock7_slip", 32'(slip_pos), 7);
    expect_eq("lock7_c", 32'({c1, c0}), 1);

    for (int i = 0; i < TMO - 1; i++) tx_word(tmds_enc(8'($urandom)));
    tx_word(T01);
    for (int m = 1; m <= TMO + 2; m++) begin
      tx_word(tmds_enc(8'($urandom)));
      if (m == TMO + 1) expect_eq("tmo_still_locked", 32'(aligned), 1);
      if (m == TMO + 2) begin
        expect_eq("tmo_drop_aligned", 32'(aligned), 0);
        expect_eq("tmo_drop_de", 32'(de), 0);
      end
    end
    for (int i = 0; i < 30; i++) tx_word(T01);
    expect_eq("relock_aligned", 32'(aligned), 1);
    expect_eq("relock_slip", 32'(slip_pos), 7);

    for (int t = 0; t < 4; t++) begin
      sh = $urandom_range(0, 9);
      tx_reset(sh, 2);
      for (int seg = 0; seg < 6; seg++) begin
        case ($urandom_range(0, 3))
          0: tk = T00;
          1: tk = T01;
          2: tk = T10;
          default: tk = T11;
        endcase
        len = (seg == 0) ? 30 : $urandom_range(12, 30);
        for (int i = 0; i < len; i++) tx_word(tk);
        len = $urandom_range(1, 300);
        for (int i = 0; i < len; i++) tx_word(tmds_enc(8'($urandom)));
      end
      expect_eq($sformatf("rand%0d_slip", t), 32'(slip_pos), sh);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
